// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares one memory port between the M-stage CPU access and an
// external (debug/DMA) master, with CPU-starvation control and an ack timeout.
module dm_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_be,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        ext_req,
   input  logic        ext_we,
   input  logic [31:0] ext_addr,
   input  logic [31:0] ext_wdata,
   input  logic [3:0]  ext_be,
   output logic        ext_gnt,
   output logic [31:0] ext_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, CPU, EXT} state_t;

   localparam int TW = $clog2(TIMEOUT) + 1;

   state_t        state;
   logic [2:0]    starve_cnt;
   logic [TW-1:0] tcnt;
   logic          timeout;
   logic          done;
   logic          grant_ext;
   logic          grant_cpu;

   // An ack arriving in the last allowed cycle wins over the abort.
   assign timeout   = (state != IDLE) && (tcnt == TW'(TIMEOUT - 1)) && !mem_ack;
   assign done      = (state != IDLE) && (mem_ack || timeout);
   assign grant_ext = (state == IDLE) && ext_req &&
                      (!cpu_req || (starve_cnt == 3'(STARVE_MAX)));
   assign grant_cpu = (state == IDLE) && cpu_req && !grant_ext;

   // NOTE: all state uses non-blocking assignments so every register samples the
   // pre-edge values; the async reset clears the request outputs immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tcnt      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else begin
         case (state)
            IDLE: begin
               tcnt <= '0;
               if (grant_ext) begin
                  state     <= EXT;
                  mem_we    <= ext_we;
                  mem_addr  <= ext_addr;
                  mem_wdata <= ext_wdata;
                  mem_be    <= ext_be;
               end else if (grant_cpu) begin
                  state     <= CPU;
                  mem_we    <= cpu_we;
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
                  mem_be    <= cpu_be;
               end
            end
            CPU, EXT: begin
               if (done) state <= IDLE;
               else      tcnt  <= tcnt + TW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Counts CPU grants that overtook a waiting external request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (!ext_req || grant_ext) begin
         starve_cnt <= '0;
      end else if (grant_cpu && (starve_cnt != 3'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + 3'd1;
      end
   end

   assign mem_req   = (state != IDLE);
   assign cpu_stall = cpu_req && !((state == CPU) && done);
   assign cpu_rdata = ((state == CPU) && mem_ack && !mem_we) ? mem_rdata : '0;
   assign ext_gnt   = (state == EXT) && done;
   assign ext_rdata = ((state == EXT) && mem_ack && !mem_we) ? mem_rdata : '0;
   assign bus_err   = timeout;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table, corner-case sequences,
// then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dm_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 16;
   localparam int NV         = 18;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0]  cpu_be;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        ext_req, ext_we;
   logic [31:0] ext_addr, ext_wdata;
   logic [3:0]  ext_be;
   logic        ext_gnt;
   logic [31:0] ext_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        bus_err;

   int tests, fails;

   always #5 clk = ~clk;

   dm_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_be(ext_be), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   typedef struct packed {
      logic        creq, cwe;
      logic [31:0] caddr, cwdata;
      logic        ereq, ewe;
      logic [31:0] eaddr, ewdata;
      logic        ack;
      logic [31:0] rdata;
      logic        stall;
      logic [31:0] crdata;
      logic        mreq, mwe;
      logic [31:0] maddr, mwdata;
      logic        gnt;
      logic [31:0] erdata;
      logic        berr;
   } vec_t;

   vec_t vecs [NV];

   // reference model: the access in flight plus the count of CPU grants that overtook EXT
   logic        m_busy, m_ext, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   int          m_age, m_streak;
   logic        cpu_fin, ext_fin;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = 4'hF;
      ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_be = 4'hF;
      mem_ack = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1;
      @(posedge clk); #1;
   endtask

   task automatic model_clear();
      m_busy = 0; m_ext = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
      m_age = 0; m_streak = 0; cpu_fin = 0; ext_fin = 0;
   endtask

   task automatic model_edge();
      logic ge, gc;
      ge = 0; gc = 0;
      if (m_busy) begin
         if (mem_ack || m_age == TIMEOUT - 1) m_busy = 0;
         else m_age++;
      end else if (ext_req && (!cpu_req || m_streak == STARVE_MAX)) begin
         ge = 1;
      end else if (cpu_req) begin
         gc = 1;
      end
      if (ge || gc) begin
         m_busy = 1; m_ext = ge; m_age = 0;
         m_we    = ge ? ext_we    : cpu_we;
         m_addr  = ge ? ext_addr  : cpu_addr;
         m_wdata = ge ? ext_wdata : cpu_wdata;
         m_be    = ge ? ext_be    : cpu_be;
      end
      if (!ext_req || ge) m_streak = 0;
      else if (gc && m_streak < STARVE_MAX) m_streak++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hi, age;
      logic seen, fin, abort, slow;
      int got [6];
      int exp_seq [6];

      tests = 0; fails = 0;

      // reset state, with cpu_stall following cpu_req while held in reset
      idle_inputs();
      reset = 0;
      cpu_req = 1;
      #12;
      check1("rst_mem_req", mem_req, 0);
      check1("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_be", {28'd0, mem_be}, 0);
      check1("rst_bus_err", bus_err, 0);
      check1("rst_ext_gnt", ext_gnt, 0);
      check1("rst_stall_hi", cpu_stall, 1);
      cpu_req = 0;
      #1 check1("rst_stall_lo", cpu_stall, 0);
      @(negedge clk) reset = 1;
      @(posedge clk); #1;

      // creq cwe caddr cwdata | ereq ewe eaddr ewdata | ack rdata |
      // stall crdata | mreq mwe maddr mwdata | gnt erdata berr
      vecs[0]  = '{0,0,32'h0,32'h0,   0,0,32'h0,32'h0,          0,32'h0,        0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[1]  = '{0,0,32'h0,32'h0,   0,0,32'h0,32'h0,          1,32'hAAAA5555, 0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[2]  = '{0,0,32'h0,32'h0,   0,0,32'h0,32'h0,          1,32'h5555AAAA, 0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[3]  = '{1,0,32'h10,32'h55, 0,0,32'h0,32'h0,          0,32'h0,        1,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[4]  = '{1,0,32'h10,32'h55, 0,0,32'h0,32'h0,          0,32'h0,        1,32'h0,        1,0,32'h10,32'h55,        0,32'h0,        0};
      vecs[5]  = '{1,1,32'hFFF0,32'h77, 1,1,32'h500,32'h9,      0,32'h0,        1,32'h0,        1,0,32'h10,32'h55,        0,32'h0,        0};
      vecs[6]  = '{1,1,32'hFFF0,32'h77, 0,0,32'h0,32'h0,        0,32'h0,        1,32'h0,        1,0,32'h10,32'h55,        0,32'h0,        0};
      vecs[7]  = '{1,0,32'h10,32'h55, 0,0,32'h0,32'h0,          1,32'hDEADBEEF, 0,32'hDEADBEEF, 1,0,32'h10,32'h55,        0,32'h0,        0};
      vecs[8]  = '{0,0,32'h0,32'h0,   0,0,32'h0,32'h0,          0,32'h0,        0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[9]  = '{0,0,32'h0,32'h0,   1,1,32'h200,32'hCAFEF00D, 0,32'h0,        0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[10] = '{0,0,32'h0,32'h0,   1,1,32'h200,32'hCAFEF00D, 1,32'h11112222, 0,32'h0,        1,1,32'h200,32'hCAFEF00D, 1,32'h0,        0};
      vecs[11] = '{0,0,32'h0,32'h0,   0,0,32'h0,32'h0,          0,32'h0,        0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[12] = '{0,0,32'h0,32'h0,   1,0,32'h300,32'h0,        0,32'h0,        0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[13] = '{0,0,32'h0,32'h0,   1,0,32'h300,32'h0,        1,32'h0BADC0DE, 0,32'h0,        1,0,32'h300,32'h0,        1,32'h0BADC0DE, 0};
      vecs[14] = '{0,0,32'h0,32'h0,   0,0,32'h0,32'h0,          0,32'h0,        0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[15] = '{1,1,32'h400,32'h99, 0,0,32'h0,32'h0,         0,32'h0,        1,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};
      vecs[16] = '{1,1,32'h400,32'h99, 0,0,32'h0,32'h0,         1,32'h12121212, 0,32'h0,        1,1,32'h400,32'h99,       0,32'h0,        0};
      vecs[17] = '{0,0,32'h0,32'h0,   0,0,32'h0,32'h0,          0,32'h0,        0,32'h0,        0,0,32'h0,32'h0,          0,32'h0,        0};

      for (int i = 0; i < NV; i++) begin
         cpu_req = vecs[i].creq;  cpu_we = vecs[i].cwe;
         cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
         ext_req = vecs[i].ereq;  ext_we = vecs[i].ewe;
         ext_addr = vecs[i].eaddr; ext_wdata = vecs[i].ewdata;
         mem_ack = vecs[i].ack;   mem_rdata = vecs[i].rdata;
         @(negedge clk);
         check1($sformatf("v%0d_stall", i), cpu_stall, vecs[i].stall);
         check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].crdata);
         check1($sformatf("v%0d_mem_req", i), mem_req, vecs[i].mreq);
         check1($sformatf("v%0d_ext_gnt", i), ext_gnt, vecs[i].gnt);
         check($sformatf("v%0d_ext_rdata", i), ext_rdata, vecs[i].erdata);
         check1($sformatf("v%0d_bus_err", i), bus_err, vecs[i].berr);
         if (vecs[i].mreq) begin
            check1($sformatf("v%0d_mem_we", i), mem_we, vecs[i].mwe);
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].mwdata);
         end
         @(posedge clk); #1;
      end

      // both masters held with immediate acks: CPU x4 then EXT then CPU
      do_reset();
      exp_seq = '{0, 0, 0, 0, 1, 0};
      got = '{2, 2, 2, 2, 2, 2};
      cpu_req = 1; cpu_addr = 32'h20; ext_req = 1; ext_addr = 32'h40; mem_ack = 1;
      n = 0;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(negedge clk);
         if (mem_req) begin
            if (ext_gnt) begin
               check("starve_ext_addr", mem_addr, 32'h40);
               got[n] = 1; n++;
            end else if (!cpu_stall) begin
               got[n] = 0; n++;
            end
         end
         @(posedge clk); #1;
      end
      check("starve_grants", n, 6);
      for (int i = 0; i < 6; i++) check($sformatf("starve_seq%0d", i), got[i], exp_seq[i]);

      // external write that is never acked aborts after TIMEOUT cycles
      do_reset();
      ext_req = 1; ext_we = 1; ext_addr = 32'h100; ext_wdata = 32'h12345678; ext_be = 4'hF;
      mem_rdata = 32'hFFFFFFFF;
      hi = 0; seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (mem_req) hi++;
         if (bus_err || ext_gnt) begin
            seen = 1;
            check1("to_bus_err", bus_err, 1);
            check1("to_ext_gnt", ext_gnt, 1);
            check("to_ext_rdata", ext_rdata, 0);
            check("to_req_cycles", hi, TIMEOUT);
            check("to_mem_wdata", mem_wdata, 32'h12345678);
            check("to_mem_be", {28'd0, mem_be}, 32'hF);
         end
         @(posedge clk); #1;
      end
      check1("to_seen", seen, 1);
      ext_req = 0;
      @(negedge clk);
      check1("to_idle_mem_req", mem_req, 0);
      check1("to_idle_bus_err", bus_err, 0);
      @(posedge clk); #1;

      // CPU read acked in the very last allowed cycle completes normally
      do_reset();
      cpu_req = 1; cpu_addr = 32'h80; mem_rdata = 32'h600D600D;
      age = 0; seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (mem_req) age++;
         mem_ack = (age == TIMEOUT);
         @(negedge clk);
         check1("late_bus_err", bus_err, 0);
         if (mem_ack) begin
            seen = 1;
            check1("late_stall", cpu_stall, 0);
            check("late_cpu_rdata", cpu_rdata, 32'h600D600D);
         end else begin
            check1("late_stall_wait", cpu_stall, 1);
         end
         @(posedge clk); #1;
      end
      check1("late_seen", seen, 1);
      mem_ack = 0; cpu_req = 0;
      @(negedge clk);
      check1("late_idle_mem_req", mem_req, 0);
      @(posedge clk); #1;

      // reset pulse in the sixth cycle of a CPU access, then re-grant
      do_reset();
      cpu_req = 1; cpu_addr = 32'hC0; mem_rdata = 32'h0C0FFEE0;
      age = 0;
      for (int c = 0; c < 20 && age < 6; c++) begin
         @(posedge clk); #1;
         if (mem_req) age++;
      end
      check("mid_rst_age", age, 6);
      #2 reset = 0;
      #1;
      check1("mid_rst_mem_req", mem_req, 0);
      check1("mid_rst_stall", cpu_stall, 1);
      check("mid_rst_cpu_rdata", cpu_rdata, 0);
      check1("mid_rst_ext_gnt", ext_gnt, 0);
      check1("mid_rst_bus_err", bus_err, 0);
      @(negedge clk) reset = 1;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk); #1;
         mem_ack = mem_req;
         #1;
         if (mem_req) begin
            seen = 1;
            check("regrant_addr", mem_addr, 32'hC0);
            check1("regrant_stall", cpu_stall, 0);
            check("regrant_rdata", cpu_rdata, 32'h0C0FFEE0);
         end
      end
      check1("regrant_seen", seen, 1);
      @(posedge clk); #1;
      mem_ack = 0; cpu_req = 0;

      // randomized traffic against the reference model
      do_reset();
      model_clear();
      for (int c = 0; c < 3000; c++) begin
         if (!cpu_req || cpu_fin) begin
            cpu_req = ($urandom_range(0, 1) == 1);
            cpu_we = $urandom_range(0, 1) == 1;
            cpu_addr = $urandom; cpu_wdata = $urandom; cpu_be = 4'($urandom);
         end
         if (!ext_req || ext_fin) begin
            ext_req = ($urandom_range(0, 3) == 0);
            ext_we = $urandom_range(0, 1) == 1;
            ext_addr = $urandom; ext_wdata = $urandom; ext_be = 4'($urandom);
         end
         slow = ((c / 128) % 2) == 1;
         mem_ack = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         @(negedge clk);
         fin   = m_busy && (mem_ack || m_age == TIMEOUT - 1);
         abort = m_busy && !mem_ack && m_age == TIMEOUT - 1;
         cpu_fin = fin && !m_ext;
         ext_fin = fin && m_ext;
         check1("r_mem_req", mem_req, m_busy);
         if (m_busy) begin
            check1("r_mem_we", mem_we, m_we);
            check("r_mem_addr", mem_addr, m_addr);
            check("r_mem_wdata", mem_wdata, m_wdata);
            check("r_mem_be", {28'd0, mem_be}, {28'd0, m_be});
         end
         check1("r_stall", cpu_stall, cpu_req && !cpu_fin);
         check("r_cpu_rdata", cpu_rdata, (cpu_fin && mem_ack && !m_we) ? mem_rdata : 32'h0);
         check1("r_ext_gnt", ext_gnt, ext_fin);
         check("r_ext_rdata", ext_rdata, (ext_fin && mem_ack && !m_we) ? mem_rdata : 32'h0);
         check1("r_bus_err", bus_err, abort);
         @(posedge clk);
         model_edge();
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
